// File: rtl/mem_interconnect.sv
// Single-outstanding CPU-to-slave memory interconnect: address decode, byte lanes, load extension.
// Define MEM_INTERCONNECT_TIMEOUT_EN to add a WAIT-state watchdog that answers with an error.
module mem_interconnect #(
  parameter int ADDR_W  = 32,
  parameter int NCH     = 4,
  parameter int DEC_MSB = 31,
  parameter int DEC_LSB = 28,
  parameter logic [NCH*(DEC_MSB-DEC_LSB+1)-1:0] CH_TAGS = {4'h8, 4'h4, 4'h2, 4'h1},
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [31:0]         req_wdata,
  output logic                rsp_valid,
  output logic [31:0]         rsp_rdata,
  output logic                rsp_err,
  output logic [NCH-1:0]      s_en,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [31:0]         s_wdata,
  output logic [4*NCH-1:0]    s_wbe,
  input  logic [32*NCH-1:0]   s_rdata,
  input  logic [NCH-1:0]      s_ack
);

  localparam int TAG_W = DEC_MSB - DEC_LSB + 1;
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic                dec_hit;
  logic [CH_W-1:0]     dec_ch;
  logic                misalign;
  logic                req_bad;
  logic                ack_sel;
  logic [31:0]         rdata_sel;
  logic [3:0]          lane_be;

`ifdef MEM_INTERCONNECT_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0]     wdog_q, wdog_d;
`endif

  // Places the addressed byte/half at bit 0 and extends it; words pass through untouched.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] size, input logic uns);
    logic [15:0] lane16;
    lane16 = 16'(word >> {off, 3'b000});
    case (size)
      2'd0:    return uns ? {24'h0, lane16[7:0]} : {{24{lane16[7]}}, lane16[7:0]};
      2'd1:    return uns ? {16'h0, lane16}      : {{16{lane16[15]}}, lane16};
      default: return word;
    endcase
  endfunction

  // Scan downward so that on duplicated tags the lowest channel is the last writer.
  always_comb begin
    dec_hit = 1'b0;
    dec_ch  = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (req_addr[DEC_MSB:DEC_LSB] == CH_TAGS[k*TAG_W +: TAG_W]) begin
        dec_hit = 1'b1;
        dec_ch  = CH_W'(k);
      end
    end
  end

  always_comb begin
    case (req_size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = req_addr[0];
      2'd2:    misalign = |req_addr[1:0];
      default: misalign = 1'b1;
    endcase
  end

  assign req_bad   = misalign | ~dec_hit;
  assign ack_sel   = s_ack[ch_q];
  assign rdata_sel = s_rdata[ch_q*32 +: 32];

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    ch_d        = ch_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef MEM_INTERCONNECT_TIMEOUT_EN
    wdog_d      = '0;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_d  = req_addr;
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          ch_d    = dec_ch;
          if (req_bad) begin
            state_d     = RESP;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d   = ISSUE;
            rsp_err_d = 1'b0;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (ack_sel) begin
          state_d     = RESP;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = we_q ? 32'h0 : load_extract(rdata_sel, addr_q[1:0], size_q, uns_q);
        end
`ifdef MEM_INTERCONNECT_TIMEOUT_EN
        else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          state_d     = RESP;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
      ch_q        <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef MEM_INTERCONNECT_TIMEOUT_EN
      wdog_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      ch_q        <= ch_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef MEM_INTERCONNECT_TIMEOUT_EN
      wdog_q      <= wdog_d;
`endif
    end
  end

  always_comb begin
    case (size_q)
      2'd0:    lane_be = 4'b0001 << addr_q[1:0];
      2'd1:    lane_be = 4'b0011 << addr_q[1:0];
      default: lane_be = 4'b1111;
    endcase
  end

  always_comb begin
    case (size_q)
      2'd0:    s_wdata = {4{wdata_q[7:0]}};
      2'd1:    s_wdata = {2{wdata_q[15:0]}};
      default: s_wdata = wdata_q;
    endcase
  end

  // Select and byte enables exist only in the single ISSUE cycle.
  always_comb begin
    s_en  = '0;
    s_wbe = '0;
    if (state_q == ISSUE) begin
      s_en[ch_q] = 1'b1;
      if (we_q) s_wbe[ch_q*4 +: 4] = lane_be;
    end
  end

  assign req_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign s_addr    = addr_q;

endmodule

// File: tb/tb_mem_interconnect.sv
// Directed self-checking bench for mem_interconnect: latency, lanes, extension, errors, reset, watchdog.
module tb_mem_interconnect;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_addr;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [3:0]    s_en;
  logic [31:0]   s_addr;
  logic [31:0]   s_wdata;
  logic [15:0]   s_wbe;
  logic [127:0]  s_rdata;
  logic [3:0]    s_ack;

  int n_vec = 0;
  int n_bad = 0;

  mem_interconnect #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .s_en(s_en), .s_addr(s_addr), .s_wdata(s_wdata), .s_wbe(s_wbe),
    .s_rdata(s_rdata), .s_ack(s_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [31:0] addr, input logic we, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_addr     = addr;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
  endtask

  // Legal access with a slave that acks at ISSUE+1; checks every cycle from accept to T+4.
  task automatic run_txn(input string tag, input logic [31:0] addr, input logic we,
                         input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                         input int ch, input logic [31:0] slave_data, input logic [31:0] exp_rdata,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    drive_req(addr, we, size, uns, wdata);
    check({tag, ".ready"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check({tag, ".en"}, 32'(s_en), 32'(1) << ch);
    check({tag, ".addr"}, s_addr, addr);
    check({tag, ".wbe"}, 32'(s_wbe), 32'(exp_be) << (4 * ch));
    if (we) check({tag, ".wdata"}, s_wdata, exp_wdata);
    tick();
    check({tag, ".en_off"}, 32'(s_en), 32'd0);
    check({tag, ".early"}, 32'(rsp_valid), 32'd0);
    s_ack[ch] = 1'b1;
    s_rdata[ch*32 +: 32] = slave_data;
    tick();
    s_ack = '0;
    check({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    check({tag, ".rdata"}, rsp_rdata, exp_rdata);
    check({tag, ".err"}, 32'(rsp_err), 32'd0);
    tick();
    check({tag, ".one_shot"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic run_err(input string tag, input logic [31:0] addr, input logic [1:0] size);
    drive_req(addr, 1'b0, size, 1'b0, 32'h0);
    tick();
    req_valid = 1'b0;
    check({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    check({tag, ".err"}, 32'(rsp_err), 32'd1);
    check({tag, ".rdata"}, rsp_rdata, 32'd0);
    check({tag, ".en"}, 32'(s_en), 32'd0);
    tick();
    check({tag, ".idle"}, 32'(rsp_valid), 32'd0);
    check({tag, ".en2"}, 32'(s_en), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got running, expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int seen;
    rst = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0; s_rdata = '0; s_ack = '0;
    tick();
    tick();
    check("rst.ready", 32'(req_ready), 32'd0);
    check("rst.valid", 32'(rsp_valid), 32'd0);
    check("rst.en", 32'(s_en), 32'd0);
    check("rst.wbe", 32'(s_wbe), 32'd0);
    check("rst.err", 32'(rsp_err), 32'd0);
    check("rst.rdata", rsp_rdata, 32'd0);
    rst = 1'b0;
    #1;
    check("rst.ready_after", 32'(req_ready), 32'd1);

    // Back-to-back: each call starts in the cycle right after the previous rsp_valid.
    run_txn("ld_word",   32'h1000_0004, 1'b0, 2'd2, 1'b0, 32'h0,         0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b0000, 32'h0);
    run_txn("ld_sbyte",  32'h1000_0003, 1'b0, 2'd0, 1'b0, 32'h0,         0, 32'h80FF_FFFF, 32'hFFFF_FF80, 4'b0000, 32'h0);
    run_txn("ld_ubyte",  32'h1000_0003, 1'b0, 2'd0, 1'b1, 32'h0,         0, 32'h80FF_FFFF, 32'h0000_0080, 4'b0000, 32'h0);
    run_txn("st_half",   32'h2000_0002, 1'b1, 2'd1, 1'b0, 32'h0000_1234, 1, 32'hFFFF_FFFF, 32'h0,         4'b1100, 32'h1234_1234);
    run_txn("st_byte",   32'h8000_0001, 1'b1, 2'd0, 1'b0, 32'h0000_00AB, 3, 32'h1234_5678, 32'h0,         4'b0010, 32'hABAB_ABAB);
    run_txn("st_word",   32'h1000_0008, 1'b1, 2'd2, 1'b0, 32'hCAFE_F00D, 0, 32'h0,         32'h0,         4'b1111, 32'hCAFE_F00D);
    run_txn("ld_shalf",  32'h4000_0002, 1'b0, 2'd1, 1'b0, 32'h0,         2, 32'h8001_7FFF, 32'hFFFF_8001, 4'b0000, 32'h0);
    run_txn("ld_shalf0", 32'h4000_0000, 1'b0, 2'd1, 1'b0, 32'h0,         2, 32'h8001_7FFF, 32'h0000_7FFF, 4'b0000, 32'h0);
    run_txn("ld_uhalf",  32'h4000_0002, 1'b0, 2'd1, 1'b1, 32'h0,         2, 32'h8001_7FFF, 32'h0000_8001, 4'b0000, 32'h0);

    run_err("unmapped",   32'h3000_0000, 2'd2);
    run_err("mis_half",   32'h1000_0001, 2'd1);
    run_err("size3",      32'h1000_0000, 2'd3);
    run_err("mis_word",   32'h2000_0002, 2'd2);

    // Ack during ISSUE and ack from a foreign channel are ignored; req_valid held busy is not queued.
    drive_req(32'h1000_0000, 1'b0, 2'd2, 1'b0, 32'h0);
    tick();
    req_addr = 32'h2000_0000;
    check("ign.en", 32'(s_en), 32'h1);
    s_ack = 4'b0001; s_rdata[31:0] = 32'h1111_1111;
    tick();
    s_ack = 4'b0010; s_rdata[63:32] = 32'h3333_3333;
    tick();
    check("ign.no_rsp", 32'(rsp_valid), 32'd0);
    s_ack = 4'b0001; s_rdata[31:0] = 32'h2222_2222;
    req_valid = 1'b0;
    tick();
    s_ack = '0;
    check("ign.valid", 32'(rsp_valid), 32'd1);
    check("ign.rdata", rsp_rdata, 32'h2222_2222);
    tick();
    check("ign.ready", 32'(req_ready), 32'd1);
    tick();
    check("ign.no_queue", 32'(s_en), 32'd0);

    // Reset while in WAIT abandons the transaction even if the ack then arrives.
    drive_req(32'h1000_0000, 1'b0, 2'd2, 1'b0, 32'h0);
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    s_ack = 4'b0001; s_rdata[31:0] = 32'h5555_5555;
    check("mrst.en", 32'(s_en), 32'd0);
    check("mrst.valid", 32'(rsp_valid), 32'd0);
    tick();
    s_ack = '0;
    check("mrst.valid2", 32'(rsp_valid), 32'd0);
    tick();
    check("mrst.valid3", 32'(rsp_valid), 32'd0);
    run_txn("post_rst", 32'h1000_0002, 1'b0, 2'd0, 1'b1, 32'h0, 0, 32'h00AB_0000, 32'h0000_00AB, 4'b0000, 32'h0);

`ifdef MEM_INTERCONNECT_TIMEOUT_EN
    // TIMEOUT=8: error after the 8th WAIT cycle; an ack in that cycle wins.
    drive_req(32'h8000_0000, 1'b0, 2'd2, 1'b0, 32'h0);
    tick();
    req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen += int'(rsp_valid);
    end
    check("wd.quiet", 32'(seen), 32'd0);
    tick();
    check("wd.valid", 32'(rsp_valid), 32'd1);
    check("wd.err", 32'(rsp_err), 32'd1);
    check("wd.rdata", rsp_rdata, 32'd0);
    tick();
    drive_req(32'h8000_0000, 1'b0, 2'd2, 1'b0, 32'h0);
    tick();
    req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen += int'(rsp_valid);
      if (i == 7) begin
        s_ack = 4'b1000; s_rdata[127:96] = 32'h7777_0001;
      end
    end
    check("wd_ack.quiet", 32'(seen), 32'd0);
    tick();
    s_ack = '0;
    check("wd_ack.valid", 32'(rsp_valid), 32'd1);
    check("wd_ack.err", 32'(rsp_err), 32'd0);
    check("wd_ack.rdata", rsp_rdata, 32'h7777_0001);
    tick();
`else
    // Without the watchdog a silent slave just stalls; the late ack completes normally.
    drive_req(32'h8000_0004, 1'b0, 2'd2, 1'b0, 32'h0);
    tick();
    req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen += int'(rsp_valid);
    end
    check("stall.quiet", 32'(seen), 32'd0);
    s_ack = 4'b1000; s_rdata[127:96] = 32'h0BAD_F00D;
    tick();
    s_ack = '0;
    check("stall.valid", 32'(rsp_valid), 32'd1);
    check("stall.err", 32'(rsp_err), 32'd0);
    check("stall.rdata", rsp_rdata, 32'h0BAD_F00D);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_interconnect.md
MEM_INTERCONNECT -- requirements
Module: mem_interconnect

Interface
REQ-001 SHALL have parameters: ADDR_W, default 32, address width; NCH, default 4, slave channel count (1..8); DEC_MSB, default 31, and DEC_LSB, default 28, bounds of the decode field; CH_TAGS, default {4'h8,4'h4,4'h2,4'h1} (ch3..ch0), flattened per-channel decode tags; TIMEOUT, default 255, watchdog limit in cycles.
REQ-002 SHALL have ports: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-003 SHALL have CPU request ports: req_valid in 1; req_ready out 1; req_addr in ADDR_W; req_we in 1; req_size in 2 (0 byte, 1 half, 2 word); req_unsigned in 1; req_wdata in 32.
REQ-004 SHALL have CPU response ports: rsp_valid out 1; rsp_rdata out 32; rsp_err out 1.
REQ-005 SHALL have slave ports: s_en out NCH, one-hot select; s_addr out ADDR_W, shared; s_wdata out 32, lane-replicated; s_wbe out 4*NCH, per-channel byte enables; s_rdata in 32*NCH; s_ack in NCH, per-channel completion.

Function
REQ-006 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP, and hold exactly one transaction outstanding.
REQ-007 SHALL drive req_ready=1 only in IDLE and accept a request on req_valid&req_ready, registering addr, we, size, unsigned, and wdata.
REQ-008 SHALL decode channel k where req_addr[DEC_MSB:DEC_LSB]==tag k; if tags are duplicated, the lowest k wins.
REQ-009 SHALL treat half accesses with addr[0]!=0, word accesses with addr[1:0]!=0, req_size==3, and unmapped addresses as errors: go IDLE->RESP directly, assert no s_en, and return rsp_err=1 with rsp_rdata=0.
REQ-010 SHALL go IDLE->ISSUE on a legal accept, and in ISSUE assert s_en[k] for exactly one cycle with s_addr equal to the latched address, then go to WAIT.
REQ-011 SHALL, on a store, set s_wbe[k] to 0001<<off for byte, 0011<<off for half, and 1111 for word; s_wbe SHALL be 0 on loads and on all other channels; s_wdata SHALL replicate the byte or half across all lanes.
REQ-012 SHALL, in WAIT, on s_ack[k] latch s_rdata[k] and go to RESP; s_ack of non-selected channels SHALL be ignored; an ack in the ISSUE cycle itself SHALL be ignored.
REQ-013 SHALL, in RESP, assert rsp_valid for exactly one cycle and then go to IDLE; responses have no backpressure.
REQ-014 SHALL, on a load, set rsp_rdata to the addressed byte or half shifted down by addr[1:0], sign-extended, or zero-extended when req_unsigned=1; a word load SHALL return the unmodified word; a store SHALL return rsp_rdata=0.
REQ-015 SHALL, for a slave acking at ISSUE+1 (BRAM), give latency accept=T, s_en=T+1, ack=T+2, rsp_valid=T+3; error responses SHALL give rsp_valid=T+1.
REQ-016 SHALL allow a next accept in the cycle after rsp_valid, so the back-to-back throughput is one transaction per 4 cycles.
REQ-017 SHALL ignore req_valid while not in IDLE, and SHALL NOT queue it.

Reset
REQ-018 SHALL, on rst, enter IDLE and zero s_en, s_wbe, rsp_valid, rsp_err, rsp_rdata, and the watchdog counter; req_ready SHALL be 0 during the reset cycle.
REQ-019 SHALL, on rst mid-transaction, abandon the transaction, produce no response, and leave no s_en asserted in the following cycle.

Configuration
REQ-020 SHALL, with MEM_INTERCONNECT_TIMEOUT_EN defined, count cycles in WAIT; when the count reaches TIMEOUT without an ack it SHALL go to RESP with rsp_err=1 and rsp_rdata=0. An ack arriving in the expiry cycle SHALL win, giving a normal response.
REQ-021 SHALL, without MEM_INTERCONNECT_TIMEOUT_EN, wait in WAIT indefinitely, include no counter logic, and never assert rsp_err for a mapped, aligned access.

Verification
REQ-022 Word load 0x1000_0004, ch0 acks at ISSUE+1 with 0xDEAD_BEEF -> rsp_valid at T+3, rsp_rdata=0xDEAD_BEEF, rsp_err=0.
REQ-023 Signed byte load 0x1000_0003 with data 0x80FF_FFFF -> rsp_rdata=0xFFFF_FF80; the same access with req_unsigned=1 -> 0x0000_0080.
REQ-024 Half store 0x2000_0002 with wdata 0x0000_1234 -> s_en=0010, s_wbe[7:4]=1100, s_wdata=0x1234_1234, others' wbe=0.
REQ-025 Load 0x3000_0000 (unmapped), then half load 0x1000_0001 (misaligned) -> each gives rsp_err=1 at T+1 with s_en never asserted.
REQ-026 TIMEOUT_EN with TIMEOUT=8, ch3 never acks -> rsp_err=1 after 8 WAIT cycles; a repeat with the ack on the 8th cycle -> normal data, rsp_err=0.
REQ-027 rst asserted in WAIT, then ack arrives -> no rsp_valid; next request is accepted normally.
